// File: rtl/fp12_pkg.sv
// fp12_pkg: shared float12 definitions for the accumulator slice.
//   float12 layout: [11] sign, [10:6] exponent (bias 15), [5:0] mantissa.
//   An exponent field of zero encodes zero (12'h000 and 12'h800 are both zero).
package fp12_pkg;

  localparam int FP12_W     = 12;
  localparam int FP12_EXP_W = 5;
  localparam int FP12_MAN_W = 6;
  localparam int FP12_BIAS  = 15;

  typedef logic [FP12_W-1:0] fp12_t;

  localparam fp12_t FP12_ZERO = 12'h000;
  localparam fp12_t FP12_ONE  = 12'h3C0;

  typedef enum logic [1:0] {
    ACCUM,
    REDUCE,
    OUT
  } accum_state_t;

endpackage

// File: rtl/add_12.sv
// add_12: pipelined float12 adder.
//   The sum is computed exactly on a wide aligned integer, then rounded once
//   to nearest-even. A zero operand returns the other operand unchanged.
//   Results above the largest finite value saturate to it; results below the
//   smallest normal flush to 12'h000. Exact cancellation gives 12'h000.
// Ports:
//   clk_i       clock
//   rst_n_i     asynchronous active-low reset, clears the pipeline
//   data_1_i    operand 1
//   data_2_i    operand 2
//   data_sum_o  data_1_i + data_2_i, ADD_LAT cycles after the operands
module add_12
  import fp12_pkg::*;
#(
  parameter int ADD_LAT = 4
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  fp12_t data_1_i,
  input  fp12_t data_2_i,
  output fp12_t data_sum_o
);

  // 7-bit significand shifted by up to 30 exponent steps, plus a carry bit.
  localparam int MAG_W = 38;

  logic                    a_zero, b_zero, a_big;
  logic                    s_big, s_small, res_sign;
  logic [FP12_EXP_W-1:0]   e_big, e_small, d;
  logic [FP12_MAN_W:0]     m_big, m_small;
  logic [MAG_W-1:0]        w_big, w_small, mag, norm;
  logic [5:0]              p;
  logic [FP12_MAN_W:0]     kept;
  logic                    round_up;
  logic [FP12_MAN_W+1:0]   kept_r;
  logic [FP12_MAN_W-1:0]   mant_n;
  logic signed [7:0]       er;
  fp12_t                   sum_c;
  fp12_t                   pipe [ADD_LAT];

  always_comb begin
    a_zero  = (data_1_i[FP12_W-2 -: FP12_EXP_W] == '0);
    b_zero  = (data_2_i[FP12_W-2 -: FP12_EXP_W] == '0);
    a_big   = (data_1_i[FP12_W-2 -: FP12_EXP_W] >= data_2_i[FP12_W-2 -: FP12_EXP_W]);
    e_big   = a_big ? data_1_i[FP12_W-2 -: FP12_EXP_W] : data_2_i[FP12_W-2 -: FP12_EXP_W];
    e_small = a_big ? data_2_i[FP12_W-2 -: FP12_EXP_W] : data_1_i[FP12_W-2 -: FP12_EXP_W];
    m_big   = {1'b1, a_big ? data_1_i[FP12_MAN_W-1:0] : data_2_i[FP12_MAN_W-1:0]};
    m_small = {1'b1, a_big ? data_2_i[FP12_MAN_W-1:0] : data_1_i[FP12_MAN_W-1:0]};
    s_big   = a_big ? data_1_i[FP12_W-1] : data_2_i[FP12_W-1];
    s_small = a_big ? data_2_i[FP12_W-1] : data_1_i[FP12_W-1];
    d       = e_big - e_small;

    // Align by shifting the larger operand up, so nothing is lost: mag is the
    // exact magnitude in units of 2^(e_small - bias - 6).
    w_big   = MAG_W'(m_big) << d;
    w_small = MAG_W'(m_small);
    if (s_big == s_small) begin
      mag      = w_big + w_small;
      res_sign = s_big;
    end else if (w_big >= w_small) begin
      mag      = w_big - w_small;
      res_sign = s_big;
    end else begin
      mag      = w_small - w_big;
      res_sign = s_small;
    end

    p = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) p = 6'(i);
    end

    // Left-justify: top 7 bits are the significand, then guard, then sticky.
    norm     = mag << (6'(MAG_W - 1) - p);
    kept     = norm[MAG_W-1 -: FP12_MAN_W+1];
    round_up = norm[MAG_W-FP12_MAN_W-2] & ((|norm[MAG_W-FP12_MAN_W-3:0]) | kept[0]);
    kept_r   = {1'b0, kept} + {{(FP12_MAN_W+1){1'b0}}, round_up};
    // Rounding carry out of 1.111111 renormalises to 1.000000 one exponent up.
    mant_n   = kept_r[FP12_MAN_W+1] ? kept_r[FP12_MAN_W:1] : kept_r[FP12_MAN_W-1:0];
    er       = $signed({2'b00, p}) + $signed({3'b000, e_small}) - 8'sd6
               + $signed({7'b0000000, kept_r[FP12_MAN_W+1]});

    if (a_zero && b_zero)  sum_c = FP12_ZERO;
    else if (a_zero)       sum_c = data_2_i;
    else if (b_zero)       sum_c = data_1_i;
    else if (mag == '0)    sum_c = FP12_ZERO;
    else if (er > 8'sd31)  sum_c = {res_sign, 5'h1F, 6'h3F};
    else if (er < 8'sd1)   sum_c = FP12_ZERO;
    else                   sum_c = {res_sign, er[FP12_EXP_W-1:0], mant_n};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ADD_LAT; i++) pipe[i] <= FP12_ZERO;
    end else begin
      pipe[0] <= sum_c;
      for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign data_sum_o = pipe[ADD_LAT-1];

endmodule

// File: rtl/accum_12.sv
// accum_12: streaming float12 dot-product accumulator.
//   Sums one last_i-delimited vector at one element per cycle. ADD_LAT partial
//   sums rotate through the add_12 feedback loop (slot = issue cycle mod
//   ADD_LAT); after the last element the slots are combined pairwise in a
//   fixed tree order, oldest slot first.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high; valid never depends on ready, and the sender holds data
//   stable while valid is high and ready is low.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   data_i       float12 product
//   valid_i      data_i valid
//   last_i       data_i ends the vector (only counts when accepted)
//   ready_o      data_i accepted this cycle (ACCUM only)
//   sum_o        float12 vector sum
//   sum_valid_o  sum_o valid, held until sum_ready_i
//   sum_ready_i  downstream accepts sum_o
//   state_o      current FSM state (debug)
module accum_12
  import fp12_pkg::*;
#(
  parameter int ADD_LAT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  fp12_t        data_i,
  input  logic         valid_i,
  input  logic         last_i,
  output logic         ready_o,
  output fp12_t        sum_o,
  output logic         sum_valid_o,
  input  logic         sum_ready_i,
  output accum_state_t state_o
);

  localparam int LOG2_LAT = $clog2(ADD_LAT);
  localparam int ROUND_W  = $clog2(LOG2_LAT + 1);

  accum_state_t         state_q, state_d;
  logic [ADD_LAT-1:0]   live_q;
  logic [LOG2_LAT-1:0]  pos_q;
  logic [ROUND_W-1:0]   round_q;
  fp12_t                hold_q, sum_q;
  logic                 rdy_en_q;

  logic                 rst_n, live_out, accept, reduce_done;
  logic                 pair_hold, pair_issue, hold_load, add_tag;
  fp12_t                fb, add_data_1, add_data_2, add_sum;
  int unsigned          lo_ones, pos_bits;

  assign rst_n    = ~rst_i;
  assign live_out = live_q[ADD_LAT-1];
  assign fb       = live_out ? add_sum : FP12_ZERO;
  // rdy_en_q keeps ready_o low until the first edge after reset release.
  assign accept   = rdy_en_q && (state_q == ACCUM) && valid_i;

  // Reduction schedule: in round r the pair partner is held when the low r+1
  // bits of pos are 0 followed by r ones, and issued when they are all ones.
  always_comb begin
    lo_ones    = (32'd1 << round_q) - 32'd1;
    pos_bits   = 32'(pos_q) & ((32'd2 << round_q) - 32'd1);
    pair_hold  = (round_q < ROUND_W'(LOG2_LAT)) && (pos_bits == lo_ones);
    pair_issue = (round_q < ROUND_W'(LOG2_LAT)) &&
                 (pos_bits == (lo_ones | (32'd1 << round_q)));
  end

  // Once all rounds are issued, the final sum emerges on the last pos of the
  // extra round.
  assign reduce_done = (round_q == ROUND_W'(LOG2_LAT)) && (pos_q == '1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (accept && last_i) state_d = REDUCE;
      REDUCE:  if (reduce_done)      state_d = OUT;
      OUT:     if (sum_ready_i)      state_d = ACCUM;
      default:                       state_d = ACCUM;
    endcase
  end

  always_comb begin
    ready_o     = 1'b0;
    sum_valid_o = 1'b0;
    add_data_1  = FP12_ZERO;
    add_data_2  = FP12_ZERO;
    add_tag     = 1'b0;
    hold_load   = 1'b0;
    unique case (state_q)
      ACCUM: begin
        ready_o    = rdy_en_q;
        add_data_2 = fb;
        if (accept) begin
          add_data_1 = data_i;
          add_tag    = 1'b1;
        end else begin
          // Bubble: the slot keeps rotating with its current liveness.
          add_tag    = live_out;
        end
      end
      REDUCE: begin
        if (pair_hold) begin
          hold_load = 1'b1;
        end else if (pair_issue) begin
          add_data_1 = hold_q;
          add_data_2 = fb;
          add_tag    = 1'b1;
        end
      end
      OUT: sum_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_en_q <= 1'b0;
      live_q   <= '0;
      pos_q    <= '0;
      round_q  <= '0;
      hold_q   <= FP12_ZERO;
      sum_q    <= FP12_ZERO;
    end else begin
      rdy_en_q <= 1'b1;
      live_q   <= {live_q[ADD_LAT-2:0], add_tag};
      if (hold_load) hold_q <= fb;
      if (state_q == REDUCE && state_d == REDUCE) begin
        pos_q <= pos_q + LOG2_LAT'(1);
        if (pos_q == '1) round_q <= round_q + ROUND_W'(1);
      end else begin
        pos_q   <= '0;
        round_q <= '0;
      end
      if (state_q == REDUCE && state_d == OUT) sum_q <= fb;
    end
  end

  add_12 #(
    .ADD_LAT(ADD_LAT)
  ) u_add (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n),
    .data_1_i  (add_data_1),
    .data_2_i  (add_data_2),
    .data_sum_o(add_sum)
  );

  assign sum_o   = sum_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_accum_12.sv
// tb_accum_12: directed and randomized checks of accum_12 (ADD_LAT = 4).
//   Reference: operands are decoded to exact scaled integers, summed, and
//   re-encoded with round-to-nearest-even; slot sums and the tree order are
//   rebuilt from the accept cycles.
module tb_accum_12;
  import fp12_pkg::*;

  logic         clk;
  logic         rst_i;
  fp12_t        data_i;
  logic         valid_i;
  logic         last_i;
  logic         ready_o;
  fp12_t        sum_o;
  logic         sum_valid_o;
  logic         sum_ready_i;
  accum_state_t state_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_last   = 0;
  bit last_acc = 0;
  logic [11:0] slot [4];

  accum_12 #(.ADD_LAT(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .ready_o    (ready_o),
    .sum_o      (sum_o),
    .sum_valid_o(sum_valid_o),
    .sum_ready_i(sum_ready_i),
    .state_o    (state_o)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model
  function automatic longint fp_val(input logic [11:0] x);
    longint v;
    if (x[10:6] == 5'd0) return 0;
    v = longint'({1'b1, x[5:0]}) <<< (int'(x[10:6]) - 1);
    return x[11] ? -v : v;
  endfunction

  function automatic logic [11:0] fp_enc(input longint s);
    longint m, kept, rem, half;
    int p, e, sh;
    logic sg;
    if (s == 0) return 12'h000;
    sg = (s < 0);
    m = sg ? -s : s;
    p = 0;
    for (int i = 0; i < 62; i++) if (m >= (longint'(1) <<< i)) p = i;
    e = p - 5;
    if (p <= 6) begin
      kept = m <<< (6 - p);
    end else begin
      sh   = p - 6;
      kept = m >>> sh;
      rem  = m - (kept <<< sh);
      half = longint'(1) <<< (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 1;
      if (kept == 128) begin
        kept = 64;
        e = e + 1;
      end
    end
    if (e > 31) return {sg, 5'h1F, 6'h3F};
    if (e < 1) return 12'h000;
    return {sg, e[4:0], kept[5:0]};
  endfunction

  function automatic logic [11:0] fp_add(input logic [11:0] a, input logic [11:0] b);
    return fp_enc(fp_val(a) + fp_val(b));
  endfunction

  // ((oldest + next) + (next + newest)) over the four slots ending at t_last
  function automatic logic [11:0] model_sum();
    logic [11:0] r0, r1;
    r0 = fp_add(slot[(t_last + 1) % 4], slot[(t_last + 2) % 4]);
    r1 = fp_add(slot[(t_last + 3) % 4], slot[t_last % 4]);
    return fp_add(r0, r1);
  endfunction

  function automatic logic [11:0] rand_fp();
    logic [4:0] e;
    if ($urandom_range(0, 9) == 0) return 12'h800;
    e = 5'($urandom_range(12, 18));
    return {1'($urandom), e, 6'($urandom)};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 4; i++) slot[i] = 12'h000;
  endtask

  task automatic push(input logic [11:0] x, input bit last);
    int c;
    c = cyc;
    valid_i = 1'b1;
    data_i  = x;
    last_i  = last;
    last_acc = ready_o;
    if (ready_o) begin
      slot[c % 4] = fp_add(slot[c % 4], x);
      if (last) t_last = c;
    end
    tick();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle();
    valid_i = 1'b0;
    data_i  = 12'($urandom);
    last_i  = 1'($urandom);
    tick();
    last_i  = 1'b0;
  endtask

  // Waits (bounded) for sum_valid_o; checks latency from the last accept and the sum.
  task automatic wait_sum(input string tag, input logic [11:0] exp, input bit noisy);
    int seen;
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      if (sum_valid_o) begin
        seen = cyc;
        break;
      end
      if (noisy) begin
        valid_i = 1'($urandom);
        last_i  = 1'($urandom);
        data_i  = 12'($urandom);
      end else begin
        valid_i = 1'b0;
        last_i  = 1'b0;
      end
      tick();
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    check({tag, "_lat"}, seen, t_last + 13);
    check({tag, "_sum"}, sum_o, exp);
  endtask

  task automatic handshake(input string tag);
    sum_ready_i = 1'b1;
    tick();
    sum_ready_i = 1'b0;
    check({tag, "_hs_valid"}, sum_valid_o, 1'b0);
    check({tag, "_hs_ready"}, ready_o, 1'b1);
  endtask

  // stimulus + scoreboard
  initial begin
    logic [11:0] exp_q[$];
    logic [11:0] e;
    int lows, stale, len;

    rst_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = 12'h000; sum_ready_i = 1'b0;
    clear_slots();
    tick();
    tick();
    check("rst_ready", ready_o, 1'b0);
    check("rst_valid", sum_valid_o, 1'b0);
    check("rst_sum", sum_o, 12'h000);
    check("rst_state", 32'(state_o), 32'(ACCUM));
    rst_i = 1'b0;
    tick();
    check("rel_ready", ready_o, 1'b1);

    // 1: single element
    push(FP12_ONE, 1'b1);
    wait_sum("t1", 12'h3C0, 1'b0);
    clear_slots();
    handshake("t1");

    // 2: eight back-to-back ones
    for (int k = 0; k < 8; k++) push(FP12_ONE, k == 7);
    wait_sum("t2", 12'h480, 1'b0);
    clear_slots();
    handshake("t2");

    // 3: sixteen ones, valid toggling
    lows = 0;
    for (int k = 0; k < 16; k++) begin
      if (!ready_o) lows++;
      push(FP12_ONE, k == 15);
      if (k < 15) begin
        if (!ready_o) lows++;
        idle();
      end
    end
    check("t3_ready_lows", lows, 0);
    wait_sum("t3", 12'h4C0, 1'b0);
    clear_slots();
    handshake("t3");

    // 4: 1.0 + -1.0
    push(12'h3C0, 1'b0);
    push(12'hBC0, 1'b1);
    wait_sum("t4", 12'h000, 1'b0);
    clear_slots();
    handshake("t4");

    // 5: downstream stall, then immediate next vector
    push(FP12_ONE, 1'b1);
    wait_sum("t5a", 12'h3C0, 1'b0);
    clear_slots();
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_hold_valid", sum_valid_o, 1'b1);
      check("t5_hold_sum", sum_o, 12'h3C0);
      check("t5_hold_ready", ready_o, 1'b0);
    end
    handshake("t5a");
    push(12'h400, 1'b1);
    check("t5_accept", last_acc, 1'b1);
    wait_sum("t5b", 12'h400, 1'b0);
    clear_slots();
    handshake("t5b");

    // 6: reset during reduction round 1
    push(FP12_ONE, 1'b0);
    push(FP12_ONE, 1'b0);
    push(12'h400, 1'b1);
    while (cyc < t_last + 6) tick();
    check("t6_state_reduce", 32'(state_o), 32'(REDUCE));
    rst_i = 1'b1;
    #1;
    check("t6_rst_ready", ready_o, 1'b0);
    check("t6_rst_valid", sum_valid_o, 1'b0);
    check("t6_rst_sum", sum_o, 12'h000);
    check("t6_rst_state", 32'(state_o), 32'(ACCUM));
    clear_slots();
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check("t6_rel_ready", ready_o, 1'b1);
    stale = 0;
    for (int k = 0; k < 16; k++) begin
      if (sum_valid_o) stale++;
      idle();
    end
    check("t6_no_stale", stale, 0);
    push(12'h400, 1'b0);
    push(12'h3C0, 1'b1);
    wait_sum("t6", 12'h420, 1'b0);
    clear_slots();
    handshake("t6");

    // randomized vectors with bubbles, stalled-side noise and downstream delay
    for (int v = 0; v < 18; v++) begin
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        while ($urandom_range(0, 2) == 0) idle();
        push(rand_fp(), k == len - 1);
      end
      exp_q.push_back(model_sum());
      clear_slots();
      e = exp_q.pop_front();
      wait_sum("rnd", e, 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      check("rnd_held_sum", sum_o, e);
      handshake("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
